// File: rtl/branch_sched_if.sv
// Handshake and data bundle between ID, the branch scheduler and fetch.
// The master side drives branch/operand/redirect-ready inputs; the slave side is the scheduler.
interface branch_sched_if;
  logic        flush;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_op;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic        opnd_ready;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        ds_valid;
  logic        stall_id;
  logic        br_resolved;
  logic        br_taken;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic [15:0] taken_cnt;
  logic [15:0] ntaken_cnt;

  modport master (
    output flush, br_valid, br_op, br_pc, br_offset, opnd_ready, rs_val, rt_val,
           ds_valid, redir_ready,
    input  br_ready, stall_id, br_resolved, br_taken, redir_valid, redir_pc,
           taken_cnt, ntaken_cnt
  );

  modport slave (
    input  flush, br_valid, br_op, br_pc, br_offset, opnd_ready, rs_val, rt_val,
           ds_valid, redir_ready,
    output br_ready, stall_id, br_resolved, br_taken, redir_valid, redir_pc,
           taken_cnt, ntaken_cnt
  );
endinterface

// File: rtl/branch_sched.sv
// Branch resolution scheduler: waits for operands, evaluates the condition, lets the
// delay slot through, then holds a redirect to fetch. Keeps wrapping outcome counters.
//
// state | meaning
// IDLE  | ready to accept a branch from ID
// OPND  | branch held, waiting for forwarded operands (ID stalled)
// DSLOT | taken branch resolved, waiting for the delay slot to reach ID
// REDIR | redirect presented to fetch until accepted (ID stalled)
module branch_sched (
  input  logic          clk,
  input  logic          rst,
  branch_sched_if.slave br
);

  typedef enum logic [1:0] {IDLE, OPND, DSLOT, REDIR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] target_q, target_d;
  logic        br_resolved_q, br_resolved_d;
  logic        br_taken_q, br_taken_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] ntaken_cnt_q, ntaken_cnt_d;

  logic        br_ready_w;
  logic        accept;
  logic        eval_en;
  logic [2:0]  eval_op;
  logic        cond;
  logic        eq, zero, neg;

  assign br_ready_w = (state_q == IDLE) & ~br.flush & ~rst;
  assign accept     = br.br_valid & br_ready_w;
  // In IDLE the branch is evaluated straight off the ID bus; later from the captured op.
  assign eval_op    = (state_q == IDLE) ? br.br_op : op_q;
  assign eval_en    = br.opnd_ready & ~br.flush & (accept | (state_q == OPND));

  assign eq   = (br.rs_val == br.rt_val);
  assign zero = (br.rs_val == 32'd0);
  assign neg  = br.rs_val[31];

  always_comb begin
    cond = 1'b0;
    case (eval_op)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b010:  cond = neg | zero;
      3'b011:  cond = ~neg & ~zero;
      3'b100:  cond = neg;
      3'b101:  cond = ~neg;
      3'b110:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    target_d      = target_q;
    br_resolved_d = 1'b0;
    br_taken_d    = br_taken_q;
    taken_cnt_d   = taken_cnt_q;
    ntaken_cnt_d  = ntaken_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = br.br_op;
          // Only the target is needed later, so pc/offset are kept in that form.
          target_d = br.br_pc + 32'd4 + {{14{br.br_offset[15]}}, br.br_offset, 2'b00};
          if (br.opnd_ready) state_d = cond ? DSLOT : IDLE;
          else               state_d = OPND;
        end
      end
      OPND: begin
        if (br.opnd_ready) state_d = cond ? DSLOT : IDLE;
      end
      DSLOT: begin
        if (br.ds_valid) state_d = REDIR;
      end
      REDIR: begin
        if (br.redir_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (eval_en) begin
      br_resolved_d = 1'b1;
      br_taken_d    = cond;
      if (cond) taken_cnt_d  = taken_cnt_q + 16'd1;
      else      ntaken_cnt_d = ntaken_cnt_q + 16'd1;
    end

    if (br.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= 3'd0;
      target_q      <= 32'd0;
      br_resolved_q <= 1'b0;
      br_taken_q    <= 1'b0;
      taken_cnt_q   <= 16'd0;
      ntaken_cnt_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      target_q      <= target_d;
      br_resolved_q <= br_resolved_d;
      br_taken_q    <= br_taken_d;
      taken_cnt_q   <= taken_cnt_d;
      ntaken_cnt_q  <= ntaken_cnt_d;
    end
  end

  assign br.br_ready    = br_ready_w;
  assign br.stall_id    = (state_q == OPND) | (state_q == REDIR);
  assign br.redir_valid = (state_q == REDIR);
  assign br.redir_pc    = target_q;
  assign br.br_resolved = br_resolved_q;
  assign br.br_taken    = br_taken_q;
  assign br.taken_cnt   = taken_cnt_q;
  assign br.ntaken_cnt  = ntaken_cnt_q;

endmodule

// File: tb/tb_branch_sched.sv
// Self-checking bench for branch_sched: directed plan cases, randomized branches
// against a transaction-level reference, flush/reset corner cases and counter wrap.
module tb_branch_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_sched_if bus ();
  branch_sched dut (.clk(clk), .rst(rst), .br(bus));

  int checks = 0;
  int failures = 0;
  logic [15:0] m_tc, m_nc;

  function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    case (op)
      3'd0: return rs == rt;
      3'd1: return rs != rt;
      3'd2: return $signed(rs) <= 0;
      3'd3: return $signed(rs) > 0;
      3'd4: return $signed(rs) < 0;
      3'd5: return $signed(rs) >= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] off);
    int s;
    s = int'($signed(off));
    return pc + 32'd4 + 32'(s * 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 0; bus.br_valid = 0; bus.br_op = 0; bus.br_pc = 0; bus.br_offset = 0;
    bus.opnd_ready = 0; bus.rs_val = 0; bus.rt_val = 0; bus.ds_valid = 0; bus.redir_ready = 0;
  endtask

  // Full branch transaction: k cycles operand delay, d cycles until delay slot, r cycles redirect wait.
  // Returns inside the first cycle in which the scheduler is idle again.
  task automatic run_branch(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] off,
                            input logic [31:0] rs, input logic [31:0] rt, input int k, input int d, input int r);
    logic exp_t;
    logic [31:0] tgt;
    exp_t = ref_taken(op, rs, rt);
    tgt = ref_target(pc, off);
    bus.flush = 0;
    bus.br_valid = 1; bus.br_op = op; bus.br_pc = pc; bus.br_offset = off;
    bus.opnd_ready = (k == 0);
    bus.rs_val = (k == 0) ? rs : $urandom;
    bus.rt_val = (k == 0) ? rt : $urandom;
    bus.ds_valid = 1;
    bus.redir_ready = 1'($urandom);
    #1;
    checks++; if (bus.br_ready !== 1'b1) begin failures++; $display("FAIL accept_ready got=%b exp=1", bus.br_ready); end
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL accept_stall got=%b exp=0", bus.stall_id); end
    tick();
    bus.br_valid = 0; bus.br_op = 3'($urandom); bus.br_pc = $urandom; bus.br_offset = 16'($urandom);
    bus.ds_valid = 0;
    for (int i = 1; i <= k; i++) begin
      bus.opnd_ready = (i == k);
      bus.rs_val = (i == k) ? rs : $urandom;
      bus.rt_val = (i == k) ? rt : $urandom;
      #1;
      checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("FAIL opnd_stall cyc=%0d got=%b exp=1", i, bus.stall_id); end
      checks++; if (bus.br_resolved !== 1'b0) begin failures++; $display("FAIL opnd_early_resolve cyc=%0d got=%b exp=0", i, bus.br_resolved); end
      tick();
    end
    bus.opnd_ready = 0; bus.rs_val = $urandom; bus.rt_val = $urandom;
    bus.ds_valid = exp_t && (d == 0);
    if (exp_t) m_tc++; else m_nc++;
    #1;
    checks++; if (bus.br_resolved !== 1'b1) begin failures++; $display("FAIL resolved got=%b exp=1 op=%0d", bus.br_resolved, op); end
    checks++; if (bus.br_taken !== exp_t) begin failures++; $display("FAIL taken op=%0d rs=%h rt=%h got=%b exp=%b", op, rs, rt, bus.br_taken, exp_t); end
    checks++; if (bus.taken_cnt !== m_tc) begin failures++; $display("FAIL taken_cnt got=%h exp=%h", bus.taken_cnt, m_tc); end
    checks++; if (bus.ntaken_cnt !== m_nc) begin failures++; $display("FAIL ntaken_cnt got=%h exp=%h", bus.ntaken_cnt, m_nc); end
    checks++; if (bus.redir_valid !== 1'b0 || bus.stall_id !== 1'b0) begin failures++; $display("FAIL resolve_cycle_outputs redir=%b stall=%b exp=0,0", bus.redir_valid, bus.stall_id); end
    if (!exp_t) begin
      checks++; if (bus.br_ready !== 1'b1) begin failures++; $display("FAIL ntaken_back_to_back ready got=%b exp=1", bus.br_ready); end
      return;
    end
    tick();
    for (int j = 1; j <= d; j++) begin
      bus.ds_valid = (j == d);
      #1;
      checks++; if (bus.redir_valid !== 1'b0 || bus.stall_id !== 1'b0 || bus.br_resolved !== 1'b0)
        begin failures++; $display("FAIL dslot_outputs redir=%b stall=%b res=%b exp=0,0,0", bus.redir_valid, bus.stall_id, bus.br_resolved); end
      tick();
    end
    for (int j = 0; j <= r; j++) begin
      bus.ds_valid = 1'($urandom);
      bus.redir_ready = (j == r);
      #1;
      checks++; if (bus.redir_valid !== 1'b1) begin failures++; $display("FAIL redir_valid cyc=%0d got=%b exp=1", j, bus.redir_valid); end
      checks++; if (bus.redir_pc !== tgt) begin failures++; $display("FAIL redir_pc cyc=%0d got=%h exp=%h", j, bus.redir_pc, tgt); end
      checks++; if (bus.stall_id !== 1'b1 || bus.br_ready !== 1'b0) begin failures++; $display("FAIL redir_stall stall=%b ready=%b exp=1,0", bus.stall_id, bus.br_ready); end
      tick();
    end
    bus.redir_ready = 0; bus.ds_valid = 0;
    #1;
    checks++; if (bus.redir_valid !== 1'b0 || bus.br_ready !== 1'b1 || bus.stall_id !== 1'b0)
      begin failures++; $display("FAIL post_redir redir=%b ready=%b stall=%b exp=0,1,0", bus.redir_valid, bus.br_ready, bus.stall_id); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus.br_valid = 1;
    repeat (2) tick();
    checks++; if (bus.br_ready !== 1'b0) begin failures++; $display("FAIL rst_br_ready got=%b exp=0", bus.br_ready); end
    checks++; if ({bus.stall_id, bus.br_resolved, bus.br_taken, bus.redir_valid} !== 4'b0)
      begin failures++; $display("FAIL rst_flags got=%b exp=0000", {bus.stall_id, bus.br_resolved, bus.br_taken, bus.redir_valid}); end
    checks++; if (bus.redir_pc !== 32'd0 || bus.taken_cnt !== 16'd0 || bus.ntaken_cnt !== 16'd0)
      begin failures++; $display("FAIL rst_values pc=%h tc=%h nc=%h exp=0", bus.redir_pc, bus.taken_cnt, bus.ntaken_cnt); end
    bus.br_valid = 0;
    rst = 0;
    m_tc = 0; m_nc = 0;
    tick();
  endtask

  task automatic test_directed();
    run_branch(3'd0, 32'h0040_0000, 16'h0004, 32'h1234, 32'h1234, 0, 0, 0);
    run_branch(3'd4, 32'h0040_0100, 16'h0010, 32'h0000_0005, 32'hDEAD_BEEF, 0, 0, 0);
    run_branch(3'd5, 32'h0040_0200, 16'hFFF0, 32'h8000_0000, 32'h0, 3, 0, 0);
    run_branch(3'd1, 32'h0040_0300, 16'h8000, 32'h1, 32'h2, 0, 1, 4);
    run_branch(3'd6, 32'hFFFF_FFF8, 16'h0001, 32'h0, 32'h0, 1, 0, 0);
    run_branch(3'd7, 32'h0040_0400, 16'h0001, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] rs, rt;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: rs = 32'd0;
        1: rs = 32'h8000_0000 | $urandom;
        2: rs = 32'($urandom_range(1, 1000));
        default: rs = $urandom;
      endcase
      rt = $urandom_range(0, 1) ? rs : $urandom;
      run_branch(3'($urandom_range(0, 7)), $urandom, 16'($urandom), rs, rt,
                 $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  task automatic test_flush();
    // flush while waiting for the delay slot
    idle_inputs();
    bus.br_valid = 1; bus.br_op = 3'd6; bus.br_pc = 32'h100; bus.opnd_ready = 1;
    tick();
    idle_inputs();
    bus.flush = 1; bus.ds_valid = 1;
    m_tc++;
    #1;
    checks++; if (bus.br_resolved !== 1'b1 || bus.taken_cnt !== m_tc)
      begin failures++; $display("FAIL flush_dslot_count res=%b tc=%h exp=1,%h", bus.br_resolved, bus.taken_cnt, m_tc); end
    tick();
    bus.flush = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.redir_valid !== 1'b0 || bus.stall_id !== 1'b0 || bus.br_ready !== 1'b1)
        begin failures++; $display("FAIL flush_dslot_idle redir=%b stall=%b ready=%b exp=0,0,1", bus.redir_valid, bus.stall_id, bus.br_ready); end
      tick();
    end
    // branch presented together with flush
    idle_inputs();
    bus.flush = 1; bus.br_valid = 1; bus.br_op = 3'd6; bus.opnd_ready = 1;
    #1;
    checks++; if (bus.br_ready !== 1'b0) begin failures++; $display("FAIL flush_idle_ready got=%b exp=0", bus.br_ready); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.br_resolved !== 1'b0 || bus.taken_cnt !== m_tc || bus.ntaken_cnt !== m_nc || bus.br_ready !== 1'b1)
      begin failures++; $display("FAIL flush_idle_noaccept res=%b tc=%h nc=%h ready=%b exp=0,%h,%h,1", bus.br_resolved, bus.taken_cnt, bus.ntaken_cnt, bus.br_ready, m_tc, m_nc); end
    // flush coincident with operands arriving
    bus.br_valid = 1; bus.br_op = 3'd0; bus.opnd_ready = 0;
    tick();
    idle_inputs();
    bus.flush = 1; bus.opnd_ready = 1;
    #1;
    checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("FAIL flush_opnd_stall got=%b exp=1", bus.stall_id); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.br_resolved !== 1'b0 || bus.taken_cnt !== m_tc || bus.ntaken_cnt !== m_nc || bus.stall_id !== 1'b0)
      begin failures++; $display("FAIL flush_opnd_discard res=%b tc=%h nc=%h stall=%b", bus.br_resolved, bus.taken_cnt, bus.ntaken_cnt, bus.stall_id); end
    // flush while redirect is pending
    bus.br_valid = 1; bus.br_op = 3'd6; bus.opnd_ready = 1;
    tick();
    idle_inputs();
    bus.ds_valid = 1;
    m_tc++;
    tick();
    idle_inputs();
    bus.flush = 1;
    #1;
    checks++; if (bus.redir_valid !== 1'b1) begin failures++; $display("FAIL flush_redir_pre got=%b exp=1", bus.redir_valid); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.redir_valid !== 1'b0 || bus.stall_id !== 1'b0 || bus.br_ready !== 1'b1 || bus.taken_cnt !== m_tc)
      begin failures++; $display("FAIL flush_redir_post redir=%b stall=%b ready=%b tc=%h", bus.redir_valid, bus.stall_id, bus.br_ready, bus.taken_cnt); end
  endtask

  task automatic test_midreset();
    idle_inputs();
    bus.br_valid = 1; bus.br_op = 3'd0;
    tick();
    idle_inputs();
    #2 rst = 1;
    #1;
    checks++; if (bus.stall_id !== 1'b0 || bus.br_ready !== 1'b0 || bus.redir_pc !== 32'd0 || bus.taken_cnt !== 16'd0 || bus.ntaken_cnt !== 16'd0)
      begin failures++; $display("FAIL midreset stall=%b ready=%b pc=%h tc=%h nc=%h exp=0", bus.stall_id, bus.br_ready, bus.redir_pc, bus.taken_cnt, bus.ntaken_cnt); end
    tick();
    rst = 0;
    m_tc = 0; m_nc = 0;
    #1;
    checks++; if (bus.br_ready !== 1'b1) begin failures++; $display("FAIL midreset_idle ready=%b exp=1", bus.br_ready); end
  endtask

  task automatic test_cnt_wrap();
    idle_inputs();
    bus.br_valid = 1; bus.br_op = 3'd7; bus.opnd_ready = 1;
    for (int i = 0; i < 65535; i++) tick();
    #1;
    checks++; if (bus.ntaken_cnt !== 16'hFFFF || bus.taken_cnt !== 16'd0)
      begin failures++; $display("FAIL cnt_full nc=%h tc=%h exp=ffff,0", bus.ntaken_cnt, bus.taken_cnt); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.ntaken_cnt !== 16'h0000) begin failures++; $display("FAIL cnt_wrap nc=%h exp=0", bus.ntaken_cnt); end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_midreset();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_sched.md
# branch_sched

Branch resolution scheduler between the ID stage and the fetch unit. It accepts one decoded branch at a time and waits for forwarded operands, stalling ID while they are missing. It evaluates the branch condition with an internal equality/sign comparator, waits for the architectural delay-slot instruction to reach ID, then issues a held redirect to fetch. It also keeps wrap-around taken/not-taken statistics counters.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  exception/ERET flush; highest priority
- br_valid  in  1  ID presents a branch
- br_ready  out  1  scheduler accepts the branch this cycle
- br_op  in  3  000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 110 always-taken, 111 never-taken
- br_pc  in  32  PC of the branch instruction
- br_offset  in  16  signed word offset
- opnd_ready  in  1  rs_val/rt_val are valid (forwarding resolved) this cycle
- rs_val, rt_val  in  32  operand values
- ds_valid  in  1  delay-slot instruction is present in ID this cycle
- stall_id  out  1  hold ID stage
- br_resolved  out  1  one-cycle pulse: branch condition evaluated
- br_taken  out  1  outcome; valid with br_resolved, held until next resolution
- redir_valid  out  1  fetch redirect request
- redir_ready  in  1  fetch accepts the redirect
- redir_pc  out  32  redirect target, stable while redir_valid
- taken_cnt, ntaken_cnt  out  16  resolution statistics

## Operation
- States: IDLE, OPND, DSLOT, REDIR. Reset state is IDLE.
- Reset values: all registered outputs are 0. br_ready is 0 while rst is high.
- br_ready = (state==IDLE) & ~flush & ~rst. Acceptance is br_valid & br_ready. On acceptance, capture br_op, br_pc, and br_offset.
- Target = br_pc + 4 + {{14{off[15]}}, off, 2'b00}. Computed mod 2^32 (wrap allowed, no fault).
- Conditions:
  - eq = (rs==rt); zero = (rs==0); neg = rs[31].
  - BEQ: eq. BNE: ~eq. BLEZ: neg|zero. BGTZ: ~neg&~zero. BLTZ: neg. BGEZ: ~neg.
  - op 110 is always taken; op 111 is never taken.
  - rt_val is ignored for all ops except BEQ/BNE.
- IDLE:
  - Acceptance with opnd_ready=1: evaluate in the same cycle. Taken → DSLOT; not-taken → IDLE.
  - Acceptance with opnd_ready=0 → OPND.
- OPND: stall_id=1. When opnd_ready=1, evaluate using the current rs_val/rt_val. Taken → DSLOT, otherwise → IDLE.
- Every evaluation registers br_resolved=1 and br_taken for the next cycle. It also increments taken_cnt or ntaken_cnt (16-bit, wraps 0xFFFF→0x0000).
- DSLOT: stall_id=0, so ID may advance the delay slot. When ds_valid=1 → REDIR.
- REDIR:
  - redir_valid=1, redir_pc=target, stall_id=1.
  - When redir_valid & redir_ready → IDLE. redir_valid drops the next cycle.
  - redir_pc must not change while waiting.
- flush (any state):
  - Next state is IDLE; redir_valid and stall_id go 0 the next cycle.
  - A branch presented with flush=1 is not accepted and is not counted.
  - An evaluation in a flush cycle is discarded: no br_resolved, no count.
- br_op 111 never enters DSLOT. br_op 110 ignores operands but still waits for opnd_ready, for uniform hazard handling.

## Timing
- Accept at cycle T with operands ready:
  - br_resolved high in T+1.
  - If taken and ds_valid=1 at T+1: redir_valid high in T+2. This is the minimum redirect latency, 2 cycles.
- Operands late by k cycles: resolution and redirect shift by k; stall_id is high for those k cycles.
- stall_id is combinational from state (OPND | REDIR). br_ready is combinational from state, flush, and rst.
- ds_valid is sampled only in DSLOT. ds_valid in the acceptance cycle is ignored.
- Back-to-back: the next branch can be accepted in the cycle after a not-taken resolution, or in the cycle after redirect acceptance.
- rst asserted mid-operation: immediately IDLE, all outputs 0, counters cleared.

## Test plan
- BEQ, rs=rt=0x1234, opnd_ready=1, br_pc=0x0040_0000, off=0x0004; ds_valid at T+1, redir_ready=1 → br_taken=1 at T+1; redir_valid at T+2 with redir_pc=0x0040_0014; taken_cnt=1.
- BLTZ, rs=0x0000_0005 → br_resolved with br_taken=0; no redirect; ntaken_cnt=1; next branch accepted at T+1.
- BGEZ, opnd_ready low for 3 cycles, rs=0x8000_0000 → stall_id high 3 cycles; not-taken at resolution; no redirect.
- BNE taken, redir_ready low 4 cycles → redir_valid and redir_pc=target stable for 5 cycles; IDLE after the handshake.
- Taken branch in DSLOT, flush=1 → IDLE next cycle; redir_valid never asserts; taken_cnt still counts the earlier resolution. Flush with br_valid in IDLE → not accepted, counters unchanged.
- br_pc=0xFFFF_FFF8, off=0x0001, op 110 → redir_pc=0x0000_0000 (wrap). After 65536 not-taken resolutions, ntaken_cnt wraps to 0.
